// File: rtl/stopwatch.sv
// Pausable three-digit BCD stopwatch (decaseconds.seconds.deciseconds) with a 0.1 s prescaler.
// The count freezes with at_end set once the terminal time is reached; only rst releases it.
module stopwatch #(
   parameter int TICKS_PER_DECI  = 10_000_000,
   parameter int END_DECASECONDS = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       at_end,
   output logic [3:0] deciseconds_out,
   output logic [3:0] seconds_out,
   output logic [3:0] decaseconds_out
);

   localparam int             PW        = (TICKS_PER_DECI > 1) ? $clog2(TICKS_PER_DECI) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_DECI - 1);
   localparam logic [3:0]     END_DIGIT = 4'(END_DECASECONDS);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    deci_q, deci_d;
   logic [3:0]    sec_q, sec_d;
   logic [3:0]    deca_q, deca_d;
   logic          at_end_q, at_end_d;
   logic          enable;
   logic          tick;

   always_comb begin
      presc_d  = presc_q;
      deci_d   = deci_q;
      sec_d    = sec_q;
      deca_d   = deca_q;
      at_end_d = at_end_q;
      enable   = start & ~at_end_q;
      tick     = enable && (presc_q == PRESC_MAX);

      if (enable) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      // Ripple the carry through all three digits within one edge.
      if (tick) begin
         if (deci_q == 4'd9) begin
            deci_d = 4'd0;
            if (sec_q == 4'd9) begin
               sec_d  = 4'd0;
               deca_d = deca_q + 4'd1;
            end else begin
               sec_d = sec_q + 4'd1;
            end
         end else begin
            deci_d = deci_q + 4'd1;
         end

         if (deca_d == END_DIGIT && sec_d == 4'd0 && deci_d == 4'd0) begin
            at_end_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         deci_q   <= 4'd0;
         sec_q    <= 4'd0;
         deca_q   <= 4'd0;
         at_end_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         deci_q   <= deci_d;
         sec_q    <= sec_d;
         deca_q   <= deca_d;
         at_end_q <= at_end_d;
      end
   end

   assign at_end          = at_end_q;
   assign deciseconds_out = deci_q;
   assign seconds_out     = sec_q;
   assign decaseconds_out = deca_q;

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for stopwatch: directed scenarios plus randomized start/rst traffic,
// compared every cycle against an arithmetic model that tracks elapsed tenths as one integer.
module tb_stopwatch;

   localparam int TICKS = 4;
   localparam int ENDD  = 6;

   logic       clk;
   logic       rst;
   logic       start;
   logic       at_end;
   logic [3:0] deciseconds_out;
   logic [3:0] seconds_out;
   logic [3:0] decaseconds_out;

   int total;
   int bad;

   // Reference model: elapsed tenths, enabled cycles into the current tenth, and end flag.
   int mTenths;
   int mPhase;
   bit mEnd;

   stopwatch #(
      .TICKS_PER_DECI (TICKS),
      .END_DECASECONDS(ENDD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .at_end         (at_end),
      .deciseconds_out(deciseconds_out),
      .seconds_out    (seconds_out),
      .decaseconds_out(decaseconds_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] expVal();
      logic [3:0] d0, d1, d2;
      d0 = 4'(mTenths % 10);
      d1 = 4'((mTenths / 10) % 10);
      d2 = 4'(mTenths / 100);
      return {mEnd, d2, d1, d0};
   endfunction

   function automatic logic [12:0] dutVal();
      return {at_end, decaseconds_out, seconds_out, deciseconds_out};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelStep(input logic r, input logic s);
      if (r) begin
         mTenths = 0;
         mPhase  = 0;
         mEnd    = 0;
      end else if (s && !mEnd) begin
         mPhase++;
         if (mPhase == TICKS) begin
            mPhase = 0;
            mTenths++;
            if (mTenths == ENDD * 100) mEnd = 1;
         end
      end
   endtask

   // Drive rst/start for n cycles, advancing the model and checking after every edge.
   task automatic applyStimulus(input logic r, input logic s, input int n);
      for (int i = 0; i < n; i++) begin
         rst   = r;
         start = s;
         @(posedge clk);
         modelStep(r, s);
         #1;
         checkOutput("cycle", 32'(dutVal()), 32'(expVal()));
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      mTenths = 0;
      mPhase  = 0;
      mEnd    = 0;
      rst     = 1'b1;
      start   = 1'b1;

      // Reset wins over start
      applyStimulus(1'b1, 1'b1, 2);
      checkOutput("reset", 32'(dutVal()), 32'h0);

      // 40 enabled cycles = 10 tenths
      applyStimulus(1'b0, 1'b1, 40);
      checkOutput("run_1s", 32'(dutVal()), 32'h010);

      // Up to 9.9 s, then one tick carries through both digits
      applyStimulus(1'b0, 1'b1, 89 * TICKS);
      checkOutput("pre_carry", 32'(dutVal()), 32'h099);
      applyStimulus(1'b0, 1'b1, TICKS - 1);
      checkOutput("carry_hold", 32'(dutVal()), 32'h099);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("carry", 32'(dutVal()), 32'h100);

      // Pause keeps the partial tick
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 6);
      checkOutput("pause_pre", 32'(dutVal()), 32'h001);
      applyStimulus(1'b0, 1'b0, 100);
      checkOutput("pause_hold", 32'(dutVal()), 32'h001);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("resume_1", 32'(dutVal()), 32'h001);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("resume_2", 32'(dutVal()), 32'h002);

      // Terminal count at 60.0 s, then frozen
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, ENDD * 100 * TICKS - 1);
      checkOutput("pre_end", 32'(dutVal()), 32'h599);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("end", 32'(dutVal()), 32'h1600);
      applyStimulus(1'b0, 1'b1, 100);
      checkOutput("end_hold", 32'(dutVal()), 32'h1600);

      // Mid-run reset at 34.5 s, counting resumes afterwards
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 345 * TICKS);
      checkOutput("mid_pre", 32'(dutVal()), 32'h345);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("mid_reset", 32'(dutVal()), 32'h000);
      applyStimulus(1'b0, 1'b1, TICKS);
      checkOutput("mid_resume", 32'(dutVal()), 32'h001);

      // Random start toggling with rare resets; model checked every cycle
      for (int i = 0; i < 6000; i++) begin
         applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
